// File: rtl/sal_ddr_phy_pkg.sv
// sal_ddr_phy_pkg: command enum, ras/cas/we pin encoding and bus-reservation depth helper
package sal_ddr_phy_pkg;
  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS} cmd_t;
  function automatic logic [2:0] pin_enc(cmd_t op);
    return op == CMD_ACT ? 3'b011 :
           op == CMD_RD  ? 3'b101 :
           op == CMD_WR  ? 3'b100 :
           op == CMD_PRE ? 3'b010 :
           op == CMD_REF ? 3'b001 :
           op == CMD_MRS ? 3'b000 : 3'b111;
  endfunction
  function automatic int resv_depth(int rl, int wl, int bl);
    return (rl > wl ? rl : wl) + bl + 1;
  endfunction
endpackage

// File: rtl/sal_ddr_bus_resv.sv
// sal_ddr_bus_resv: data-bus slot reservation (in: issue_rd/issue_wr; out: rd_ok/wr_ok, wr_beat_en/wr_odt, rd_beat_en/rd_beat_last); bit k = k+1 cycles ahead
module sal_ddr_bus_resv
  import sal_ddr_phy_pkg::*;
#(
  parameter int RL = 5,
  parameter int WL = 4,
  parameter int BL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_rd,
  input  logic issue_wr,
  output logic rd_ok,
  output logic wr_ok,
  output logic wr_beat_en,
  output logic wr_odt,
  output logic rd_beat_en,
  output logic rd_beat_last
);
  localparam int D = resv_depth(RL, WL, BL);
  localparam int CW = BL > 1 ? $clog2(BL) : 1;
  localparam logic [D-1:0] ONES = '1;
  localparam logic [D-1:0] BURST = ONES >> (D - BL);
  localparam logic [D-1:0] WR_DATA = BURST << WL;
  localparam logic [D-1:0] RD_DATA = BURST << RL;
  localparam logic [D-1:0] WR_EDGE = (D'(1) << (WL - 1)) | (D'(1) << (WL + BL));
  localparam logic [D-1:0] RD_EDGE = (D'(1) << (RL - 1)) | (D'(1) << (RL + BL));
  logic [D-1:0] rd_busy, wr_busy;
  logic rd_cur;
  logic [CW-1:0] rd_idx;
  assign wr_ok = ~|((rd_busy | wr_busy) & WR_DATA) && ~|(rd_busy & WR_EDGE);
  assign rd_ok = ~|((rd_busy | wr_busy) & RD_DATA) && ~|(wr_busy & RD_EDGE);
  assign wr_beat_en = wr_busy[0];
  assign wr_odt = wr_busy[0] | wr_busy[1];
  assign rd_beat_en = rd_cur;
  assign rd_beat_last = rd_cur && rd_idx == CW'(BL - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_busy <= '0;
      wr_busy <= '0;
      rd_cur <= 1'b0;
      rd_idx <= '0;
    end else begin
      rd_busy <= (rd_busy | (issue_rd ? RD_DATA : '0)) >> 1;
      wr_busy <= (wr_busy | (issue_wr ? WR_DATA : '0)) >> 1;
      rd_cur <= rd_busy[0];
      rd_idx <= rd_cur ? rd_idx + CW'(1) : rd_idx;
    end
  end
endmodule

// File: rtl/sal_ddr_cmd_phy.sv
// sal_ddr_cmd_phy: SAL command/data front-end (cmd valid/ready in, registered DDR cmd pins, write beats wdata->dq_o at WL, read beats dq_i->rdata at RL)
module sal_ddr_cmd_phy
  import sal_ddr_phy_pkg::*;
#(
  parameter int RANKS = 1,
  parameter int DQ_WIDTH = 64,
  parameter int BA_WIDTH = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int BURST_LEN = 4,
  parameter int WL = 4,
  parameter int RL = 5,
  parameter int INIT_CKE_CYCLES = 200,
  localparam int RW = RANKS > 1 ? $clog2(RANKS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  cmd_t                    cmd_op,
  input  logic [RW-1:0]           cmd_rank,
  input  logic [BA_WIDTH-1:0]     cmd_ba,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  output logic                    wdata_ready,
  input  logic [DQ_WIDTH-1:0]     wdata,
  input  logic [DQ_WIDTH/8-1:0]   wmask,
  input  logic                    wdata_valid,
  output logic                    wdata_err,
  output logic                    rdata_valid,
  output logic                    rdata_last,
  output logic [DQ_WIDTH-1:0]     rdata,
  output logic                    cke,
  output logic                    ras_n,
  output logic                    cas_n,
  output logic                    we_n,
  output logic                    odt,
  output logic [RANKS-1:0]        cs_n,
  output logic [BA_WIDTH-1:0]     ba,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DQ_WIDTH-1:0]     dq_o,
  output logic [DQ_WIDTH/8-1:0]   dm_o,
  output logic                    dq_oe,
  output logic                    dqs_oe,
  input  logic [DQ_WIDTH-1:0]     dq_i
);
  localparam int CW = $clog2(INIT_CKE_CYCLES + 1);
  logic [CW-1:0] init_cnt;
  logic init_done, fire, rd_ok, wr_ok, wr_beat_en, wr_odt, rd_beat_en, rd_beat_last;
  assign cmd_ready = init_done && (cmd_op == CMD_RD ? rd_ok : cmd_op == CMD_WR ? wr_ok : 1'b1);
  assign fire = cmd_valid && cmd_ready;
  assign wdata_ready = wr_beat_en;
  sal_ddr_bus_resv #(.RL(RL), .WL(WL), .BL(BURST_LEN)) u_resv (
    .clk(clk),
    .rst_n(rst_n),
    .issue_rd(fire && cmd_op == CMD_RD),
    .issue_wr(fire && cmd_op == CMD_WR),
    .rd_ok(rd_ok),
    .wr_ok(wr_ok),
    .wr_beat_en(wr_beat_en),
    .wr_odt(wr_odt),
    .rd_beat_en(rd_beat_en),
    .rd_beat_last(rd_beat_last)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_cnt <= '0;
      init_done <= 1'b0;
      cke <= 1'b0;
      cs_n <= '1;
      {ras_n, cas_n, we_n} <= 3'b111;
      ba <= '0;
      addr <= '0;
      odt <= 1'b0;
      dq_oe <= 1'b0;
      dqs_oe <= 1'b0;
      dq_o <= '0;
      dm_o <= '0;
      wdata_err <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last <= 1'b0;
      rdata <= '0;
    end else begin
      init_cnt <= init_cnt == CW'(INIT_CKE_CYCLES - 1) ? init_cnt : init_cnt + CW'(1);
      cke <= init_cnt == CW'(INIT_CKE_CYCLES - 1);
      init_done <= cke;
      cs_n <= fire && cmd_op != CMD_NOP ? ~(RANKS'(1) << cmd_rank) : '1;
      {ras_n, cas_n, we_n} <= fire ? pin_enc(cmd_op) : 3'b111;
      ba <= fire ? cmd_ba : ba;
      addr <= fire ? cmd_addr : addr;
      odt <= wr_odt;
      dq_oe <= wr_beat_en;
      dqs_oe <= wr_beat_en;
      dq_o <= wr_beat_en ? wdata : dq_o;
      dm_o <= wr_beat_en ? wmask : dm_o;
      wdata_err <= wdata_err | (wr_beat_en & ~wdata_valid);
      rdata_valid <= rd_beat_en;
      rdata_last <= rd_beat_last;
      rdata <= rd_beat_en ? dq_i : rdata;
    end
  end
endmodule
